alu_issue: RTL and testbench
============================

# alu_issue

Operand-fetch, issue and writeback stage that sits directly upstream of `alu`. It holds the architectural register file and accepts one register-to-register or register-immediate ALU instruction per cycle. It drives the `alu` operation and operand inputs, tracks in-flight results, stalls on read-after-write hazards, and writes `alu` results back into the register file.

## Interface
- `WORD_SIZE`, 16, datapath width; matches `alu`.
- `REG_COUNT`, 8, number of registers; register addresses are 3 bits.
- `ALU_LATENCY`, 1, number of edges from an `alu` input change to a valid `alu` output (L below).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  an instruction is presented.
- `instr_ready`  out  1  the stage can accept; an instruction is accepted on an edge where valid and ready are both high.
- `instr_op`  in  3  ALU op code (`ALU_*` from parameters.vh); passed through, not interpreted.
- `instr_rd`, `instr_rs1`, `instr_rs2`  in  3  destination and source registers.
- `instr_imm_en`  in  1  when high, `instr_imm` replaces rs2 and rs2 is unused.
- `instr_imm`  in  WORD_SIZE  immediate operand.
- `alu_op`  out  3  to `alu` op; registered.
- `alu_in1`, `alu_in2`  out  WORD_SIZE  to `alu` in1/in2; registered.
- `alu_out`  in  WORD_SIZE  from `alu` out.
- `wb_valid`  out  1  a result is being written back this cycle.
- `wb_rd`  out  3  writeback destination.
- `wb_data`  out  WORD_SIZE  writeback value; equals `alu_out`.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  WORD_SIZE  combinational register file read; r0 reads 0.

## Operation
- **Register file:** REG_COUNT x WORD_SIZE. r0 always reads 0; writes to r0 are discarded, but `wb_valid` still pulses for them.
- **Accept:** on acceptance, `alu_op`, `alu_in1` = R[rs1] and `alu_in2` = (imm_en ? imm : R[rs2]) are registered. When nothing is accepted, the `alu_*` outputs hold their value.
- **Tag pipeline:** stages 0..L, each holding {valid, rd}.
  - Stage 0 loads {accept, instr_rd} every edge.
  - Stage k loads stage k-1 every edge.
  - Stage L drives `wb_valid` / `wb_rd`; `wb_data` = `alu_out`.
  - The register file is written at the edge ending a cycle with `wb_valid` high.
- **Hazard:** `instr_ready` = 0 when any valid stage 0..L-1 has a nonzero rd equal to rs1, or to rs2 when imm_en = 0. Stage L never blocks. `instr_ready` does not depend on `instr_valid`.
- **Forwarding:** an operand read of a register equal to a valid, nonzero stage-L rd takes `wb_data` instead of the register file. This applies to the operand path and to `dbg_data`.
- **Arithmetic:** no arithmetic in this block; widths pass through unchanged.

## Timing
- **Reset:** all registers, `alu_op`, `alu_in1`, `alu_in2` and the tag stages clear to 0.
  - Outputs during reset: `wb_valid` = 0, `wb_rd` = 0, `instr_ready` = 1.
  - Reset mid-flight discards every in-flight result: no `wb_valid` pulse and no write.
- **Latency:** an instruction accepted at edge E0 is presented to `alu` after E0. It is on `wb_*` during the cycle between E_L and E_L+1, and is architecturally written at E_L+1.
- **Throughput:**
  - Independent instructions: one accepted per cycle.
  - A dependent instruction is accepted no earlier than E_L+1; with L = 1 that is exactly one stall cycle.
- **Simultaneous events:** writeback and accept in the same cycle are legal; forwarding supplies the new value.
- **Held requests:** if an instruction is held while stalled, its fields must stay stable until accepted.

## Test plan
- **Reset:** assert `rst_n` = 0 -> `instr_ready` = 1, `wb_valid` = 0, `dbg_data` = 0 for all addresses.
- **Dependent add:** ADD r1 = r0 + imm 5, ADD r2 = r0 + imm 7 on consecutive cycles, then ADD r3 = r1 + r2 -> first two accepted back-to-back; r3 stalls one cycle; `wb_data` sequence is 5, 7, 12; `dbg_data`(r3) = 12.
- **Every op:** all eight ops with (in1, in2) as in the alu bench, e.g. SUB 15,4 and SHIFT 5,3 -> results 11 and 40 written back.
- **Write to r0:** ADD r0 = r0 + imm 9 -> `wb_valid` pulses with `wb_rd` = 0. A following ADD r4 = r0 + imm 1 is not stalled and writes 1.
- **Immediate ignores rs2:** MUL r5 = r1 * imm 9 with rs2 = a pending rd -> no stall; result 45 when r1 = 5.
- **Reset mid-flight:** accept ADD r6 = r0 + imm 3, assert reset before E_L+1 -> no `wb_valid`; `dbg_data`(r6) = 0.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: operand-fetch, issue and writeback stage in front of `alu`.
// Holds the register file, issues one ALU instruction per cycle, stalls on
// read-after-write hazards against in-flight results, and writes `alu`
// results back. r0 reads as zero and ignores writes.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   instr_valid / instr_ready   instruction handshake (accept = valid & ready)
//   instr_op                    ALU op code, passed through to alu_op
//   instr_rd/rs1/rs2            destination / source register addresses
//   instr_imm_en, instr_imm     immediate replaces rs2 when imm_en is high
//   alu_op, alu_in1, alu_in2    registered operation and operands to `alu`
//   alu_out                     result from `alu`
//   wb_valid, wb_rd, wb_data    writeback in progress this cycle
//   dbg_addr, dbg_data          combinational register read (with forwarding)
module alu_issue #(
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned REG_COUNT   = 8,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [2:0]           instr_op,
  input  logic [2:0]           instr_rd,
  input  logic [2:0]           instr_rs1,
  input  logic [2:0]           instr_rs2,
  input  logic                 instr_imm_en,
  input  logic [WORD_SIZE-1:0] instr_imm,
  output logic [2:0]           alu_op,
  output logic [WORD_SIZE-1:0] alu_in1,
  output logic [WORD_SIZE-1:0] alu_in2,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 wb_valid,
  output logic [2:0]           wb_rd,
  output logic [WORD_SIZE-1:0] wb_data,
  input  logic [2:0]           dbg_addr,
  output logic [WORD_SIZE-1:0] dbg_data
);

  logic [WORD_SIZE-1:0] rf_q [REG_COUNT];

  // Tag pipeline: stage 0 is loaded at accept, stage ALU_LATENCY is writeback.
  logic                 tag_v_q  [ALU_LATENCY+1];
  logic [2:0]           tag_rd_q [ALU_LATENCY+1];

  logic [2:0]           alu_op_q;
  logic [WORD_SIZE-1:0] alu_in1_q;
  logic [WORD_SIZE-1:0] alu_in2_q;

  logic                 accept;
  logic                 hazard;
  logic                 fwd_en;
  logic [WORD_SIZE-1:0] rs1_val;
  logic [WORD_SIZE-1:0] rs2_val;
  logic [WORD_SIZE-1:0] in2_d;

  assign wb_valid = tag_v_q[ALU_LATENCY];
  assign wb_rd    = tag_rd_q[ALU_LATENCY];
  assign wb_data  = alu_out;
  assign fwd_en   = wb_valid && (wb_rd != 3'd0);

  assign alu_op   = alu_op_q;
  assign alu_in1  = alu_in1_q;
  assign alu_in2  = alu_in2_q;

  // Register read with r0 forced to zero and bypass from the writeback stage.
  function automatic logic [WORD_SIZE-1:0] read_reg(
    input logic [2:0]           addr,
    input logic [WORD_SIZE-1:0] rf_val,
    input logic                 fwd,
    input logic [2:0]           fwd_rd,
    input logic [WORD_SIZE-1:0] fwd_data
  );
    logic [WORD_SIZE-1:0] val;
    val = rf_val;
    if (addr == 3'd0) begin
      val = '0;
    end else if (fwd && (fwd_rd == addr)) begin
      val = fwd_data;
    end
    return val;
  endfunction

  always_comb begin
    rs1_val  = read_reg(instr_rs1, rf_q[instr_rs1], fwd_en, wb_rd, wb_data);
    rs2_val  = read_reg(instr_rs2, rf_q[instr_rs2], fwd_en, wb_rd, wb_data);
    dbg_data = read_reg(dbg_addr,  rf_q[dbg_addr],  fwd_en, wb_rd, wb_data);
    in2_d    = instr_imm_en ? instr_imm : rs2_val;
  end

  // Only stages before writeback block; the writeback stage is covered by
  // the bypass above.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < ALU_LATENCY; k++) begin
      if (tag_v_q[k] && (tag_rd_q[k] != 3'd0) &&
          ((tag_rd_q[k] == instr_rs1) ||
           (!instr_imm_en && (tag_rd_q[k] == instr_rs2)))) begin
        hazard = 1'b1;
      end
    end
  end

  assign instr_ready = !hazard;
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q  <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
    end else if (accept) begin
      alu_op_q  <= instr_op;
      alu_in1_q <= rs1_val;
      alu_in2_q <= in2_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= ALU_LATENCY; k++) begin
        tag_v_q[k]  <= 1'b0;
        tag_rd_q[k] <= '0;
      end
    end else begin
      tag_v_q[0]  <= accept;
      tag_rd_q[0] <= instr_rd;
      for (int unsigned k = 1; k <= ALU_LATENCY; k++) begin
        tag_v_q[k]  <= tag_v_q[k-1];
        tag_rd_q[k] <= tag_rd_q[k-1];
      end
    end
  end

  // r0 writes are dropped here; wb_valid still pulses for them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        rf_q[i] <= '0;
      end
    end else if (fwd_en) begin
      rf_q[wb_rd] <= alu_out;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  localparam int unsigned W = 16;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         instr_valid;
  logic         instr_ready;
  logic [2:0]   instr_op;
  logic [2:0]   instr_rd;
  logic [2:0]   instr_rs1;
  logic [2:0]   instr_rs2;
  logic         instr_imm_en;
  logic [W-1:0] instr_imm;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [W-1:0] alu_out = '0;
  logic         wb_valid;
  logic [2:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic [2:0]   dbg_addr;
  logic [W-1:0] dbg_data;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [2:0]   rd;
    logic [W-1:0] data;
  } wb_t;

  wb_t          sb [$];
  wb_t          exp_wb;
  logic [W-1:0] ref_rf [8];

  // Operand table for the all-ops sweep: in1, in2 and hand-computed results.
  logic [W-1:0] ta   [8] = '{16'd15, 16'd15, 16'd15, 16'd5, 16'd12, 16'd12, 16'd12, 16'd40};
  logic [W-1:0] tb   [8] = '{16'd4,  16'd4,  16'd4,  16'd3, 16'd10, 16'd10, 16'd10, 16'd3};
  logic [W-1:0] texp [8] = '{16'd19, 16'd11, 16'd60, 16'd40, 16'd8,  16'd14, 16'd6,  16'd5};

  alu_issue #(
    .WORD_SIZE  (16),
    .REG_COUNT  (8),
    .ALU_LATENCY(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_imm_en(instr_imm_en),
    .instr_imm   (instr_imm),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_out     (alu_out),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  // Bench ALU op encoding: ADD SUB MUL SHL AND OR XOR SHR.
  function automatic logic [W-1:0] alu_f(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a * b;
      3'd3:    r = a << b[3:0];
      3'd4:    r = a & b;
      3'd5:    r = a | b;
      3'd6:    r = a ^ b;
      default: r = a >> b[3:0];
    endcase
    return r;
  endfunction

  // Single-cycle-latency ALU stand-in.
  always @(posedge clk) alu_out <= alu_f(alu_op, alu_in1, alu_in2);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Writeback monitor: every wb pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_wb = sb.pop_front();
        chk("wb_rd", {29'd0, wb_rd}, {29'd0, exp_wb.rd});
        chk("wb_data", {16'd0, wb_data}, {16'd0, exp_wb.data});
        if (dbg_addr == exp_wb.rd && exp_wb.rd != 3'd0)
          chk("dbg_fwd", {16'd0, dbg_data}, {16'd0, exp_wb.data});
      end
    end
  end

  // Presents one instruction and holds it until accepted; checks stall count.
  task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic ie,
                       input logic [W-1:0] imm, input int exp_stall);
    int           st   = 0;
    bit           done = 1'b0;
    logic [W-1:0] a, b, r;
    instr_op     = op;
    instr_rd     = rd;
    instr_rs1    = rs1;
    instr_rs2    = rs2;
    instr_imm_en = ie;
    instr_imm    = imm;
    instr_valid  = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (instr_ready === 1'b1) begin
        a = ref_rf[rs1];
        b = ie ? imm : ref_rf[rs2];
        r = alu_f(op, a, b);
        sb.push_back('{rd: rd, data: r});
        if (rd != 3'd0) ref_rf[rd] = r;
        done = 1'b1;
      end else begin
        st++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else       chk({tag, "_stall"}, st, exp_stall);
  endtask

  task automatic idle();
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_check(input string tag, input logic [2:0] a, input logic [W-1:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  initial begin
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    instr_op     = '0;
    instr_rd     = '0;
    instr_rs1    = '0;
    instr_rs2    = '0;
    instr_imm_en = 1'b0;
    instr_imm    = '0;
    dbg_addr     = '0;
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;

    // Reset state
    #2;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {29'd0, wb_rd}, 32'd0);
    chk("rst_alu_in1", {16'd0, alu_in1}, 32'd0);
    for (int i = 0; i < 8; i++) dbg_check("rst_dbg", i[2:0], 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Dependent add: r3 waits one cycle for r2, gets r1 from the file and r2 forwarded
    issue("dep_r1", OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, 0);
    issue("dep_r2", OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'd7, 0);
    issue("dep_r3", OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 1);
    idle();
    drain();
    dbg_check("dep_r3_val", 3'd3, 16'd12);

    // Every op: load r1 then r7 = r1 op imm (one stall each)
    for (int i = 0; i < 8; i++) begin
      issue("op_ld", OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, ta[i], 0);
      issue("op_x", i[2:0], 3'd7, 3'd1, 3'd0, 1'b1, tb[i], 1);
      idle();
      drain();
      dbg_check("op_res", 3'd7, texp[i]);
    end

    // Write to r0 is discarded but still pulses wb; r0 consumer does not stall
    issue("r0_wr", OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'd9, 0);
    issue("r0_dep", OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 16'd1, 0);
    idle();
    drain();
    dbg_check("r0_val", 3'd0, 16'd0);
    dbg_check("r4_val", 3'd4, 16'd1);

    // Immediate form ignores a pending rs2
    issue("imm_r1", OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, 0);
    idle();
    drain();
    issue("imm_r2", OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3, 0);
    issue("imm_mul", OP_MUL, 3'd5, 3'd1, 3'd2, 1'b1, 16'd9, 0);
    chk("imm_alu_in1", {16'd0, alu_in1}, 32'd5);
    chk("imm_alu_in2", {16'd0, alu_in2}, 32'd9);
    // r2 is now in writeback: register rs2 uses the bypass without stalling
    issue("fwd_r6", OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0, 16'd0, 0);
    chk("fwd_alu_in2", {16'd0, alu_in2}, 32'd3);
    idle();
    drain();
    dbg_check("mul_r5", 3'd5, 16'd45);
    dbg_check("fwd_r6_val", 3'd6, 16'd8);

    // Reset mid-flight drops the in-flight result
    issue("mid_r6", OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'd3, 0);
    idle();
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++) ref_rf[i] = '0;
    @(negedge clk);
    chk("mid_wb_valid0", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    chk("mid_wb_valid1", {31'd0, wb_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    dbg_check("mid_r6_val", 3'd6, 16'd0);
    chk("mid_ready", {31'd0, instr_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("end_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
